// File: rtl/pio_pkg.sv
// pio_pkg
//   Shared definitions for the parallel-input peripheral: Avalon word
//   addresses of the four register slots, the capture-edge selector type,
//   and the data-bus width.
package pio_pkg;

  // Avalon-MM word addresses
  localparam logic [1:0] PIO_DATA     = 2'd0;
  localparam logic [1:0] PIO_RESERVED = 2'd1;
  localparam logic [1:0] PIO_IRQMASK  = 2'd2;
  localparam logic [1:0] PIO_EDGECAP  = 2'd3;

  localparam int PIO_BUS_W = 32;

  // Which transition of a synchronized input bit counts as an event
  typedef enum logic [1:0] {
    EDGE_RISING  = 2'd0,
    EDGE_FALLING = 2'd1,
    EDGE_ANY     = 2'd2
  } edge_type_e;

  localparam edge_type_e PIO_ANY_EDGE = EDGE_ANY;

endpackage

// File: rtl/pio_sync.sv
// pio_sync
//   Multi-flop synchronizer that brings asynchronous external inputs into
//   the clk domain. Every bit has its own independent chain; no attempt is
//   made to keep a multi-bit word coherent.
// Ports:
//   clk       - sampling clock
//   reset_n   - asynchronous active-low reset, clears every stage
//   async_in  - raw external inputs (WIDTH bits)
//   sync_out  - output of the last stage (WIDTH bits)
module pio_sync #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out
);

  logic [WIDTH-1:0] stage_q [SYNC_STAGES];
  logic [WIDTH-1:0] stage_d [SYNC_STAGES];

  // Each stage takes the previous stage's value; stage 0 samples the pins
  always_comb begin
    stage_d[0] = async_in;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign sync_out = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/computer_system_pio_in.sv
// computer_system_pio_in
//   Avalon-MM parallel input port with per-bit edge capture and a masked,
//   registered level interrupt.
// Ports:
//   clk, reset_n  - clock and asynchronous active-low reset
//   address       - word address: 0 DATA, 1 reserved, 2 IRQMASK, 3 EDGECAP
//   chipselect    - slave select; qualifies both reads and writes
//   write_n       - active-low write strobe
//   writedata     - 32-bit write data (bits above WIDTH ignored)
//   readdata      - 32-bit combinational read data (0 when not selected)
//   in_port       - asynchronous external inputs
//   irq           - registered |(EDGECAP & IRQMASK)
module computer_system_pio_in
  import pio_pkg::*;
#(
  parameter int         WIDTH       = 8,
  parameter edge_type_e EDGE_TYPE   = EDGE_RISING,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [1:0]           address,
  input  logic                 chipselect,
  input  logic                 write_n,
  input  logic [PIO_BUS_W-1:0] writedata,
  output logic [PIO_BUS_W-1:0] readdata,
  input  logic [WIDTH-1:0]     in_port,
  output logic                 irq
);

  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] prev_q,    prev_d;
  logic [WIDTH-1:0] irqmask_q, irqmask_d;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic             irq_q,     irq_d;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] clear_bits;
  logic             wr_en;
  logic [WIDTH-1:0] rd_field;
  logic [PIO_BUS_W-1:0] rd_ext;
  logic             unused_wdata;

  // Writedata bits above WIDTH are architecturally ignored
  assign unused_wdata = ^writedata;

  pio_sync #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .async_in (in_port),
    .sync_out (sync_q)
  );

  // Edge detector between the last synchronizer stage and one extra delay.
  // Because prev_q resets to 0 together with the chain, an input held high
  // through reset is seen as a genuine rising edge once the chain fills.
  always_comb begin
    edge_det = sync_q ^ prev_q;
    case (EDGE_TYPE)
      EDGE_RISING:  edge_det = sync_q & ~prev_q;
      EDGE_FALLING: edge_det = ~sync_q & prev_q;
      default:      edge_det = sync_q ^ prev_q;
    endcase
  end

  // Next-state for the register file. On a same-cycle clear and new edge
  // the OR with edge_det is applied last, so the set wins. irq_d looks at
  // the current register values, giving one clock of latency after either
  // EDGECAP or IRQMASK changes.
  always_comb begin
    wr_en      = chipselect & ~write_n;
    prev_d     = sync_q;
    irqmask_d  = irqmask_q;
    clear_bits = '0;
    if (wr_en && (address == PIO_IRQMASK)) begin
      irqmask_d = writedata[WIDTH-1:0];
    end
    if (wr_en && (address == PIO_EDGECAP)) begin
      clear_bits = writedata[WIDTH-1:0];
    end
    edgecap_d = (edgecap_q & ~clear_bits) | edge_det;
    irq_d     = |(edgecap_q & irqmask_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q    <= '0;
      irqmask_q <= '0;
      edgecap_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      prev_q    <= prev_d;
      irqmask_q <= irqmask_d;
      edgecap_q <= edgecap_d;
      irq_q     <= irq_d;
    end
  end

  // Zero-latency read mux; reads never alter state
  always_comb begin
    rd_field = '0;
    if (chipselect) begin
      case (address)
        PIO_DATA:    rd_field = sync_q;
        PIO_IRQMASK: rd_field = irqmask_q;
        PIO_EDGECAP: rd_field = edgecap_q;
        default:     rd_field = '0;
      endcase
    end
    rd_ext = '0;
    rd_ext[WIDTH-1:0] = rd_field;
    readdata = rd_ext;
  end

  assign irq = irq_q;

endmodule

// File: tb/tb_computer_system_pio_in.sv
// tb_computer_system_pio_in
//   Drives three instances (RISING, FALLING, ANY) sharing one Avalon bus.
//   Expected values are queued when stimulus is applied and popped when the
//   corresponding output is sampled.
module tb_computer_system_pio_in;
  import pio_pkg::*;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [7:0]  in_r, in_f, in_a;
  logic [31:0] rd_r, rd_f, rd_a;
  logic        irq_r, irq_f, irq_a;

  exp_t        exp_q[$];
  exp_t        e;
  logic [31:0] got;
  int          total;
  int          bad;

  computer_system_pio_in #(.WIDTH(8), .EDGE_TYPE(EDGE_RISING), .SYNC_STAGES(2)) u_rise (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd_r), .in_port(in_r), .irq(irq_r));

  computer_system_pio_in #(.WIDTH(8), .EDGE_TYPE(EDGE_FALLING), .SYNC_STAGES(2)) u_fall (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd_f), .in_port(in_f), .irq(irq_f));

  computer_system_pio_in #(.WIDTH(8), .EDGE_TYPE(EDGE_ANY), .SYNC_STAGES(2)) u_any (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd_a), .in_port(in_a), .irq(irq_a));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every task runs inside the low phase of the clock, so writes land on
  // the next rising edge and reads never straddle one.
  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; address = 2'd0; writedata = '0;
  endtask

  task automatic bus_read(input int dut, input logic [1:0] a, output logic [31:0] v);
    chipselect = 1'b1; write_n = 1'b1; address = a;
    #1;
    case (dut)
      0:       v = rd_r;
      1:       v = rd_f;
      default: v = rd_a;
    endcase
    chipselect = 1'b0; address = 2'd0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; in_r = 8'hA5; in_f = 8'h00; in_a = 8'h00;
    chipselect = 1'b0; write_n = 1'b1; address = 2'd0; writedata = '0;
    exp_q.push_back('{"rst_data", 32'h0});
    exp_q.push_back('{"rst_edgecap", 32'h0});
    exp_q.push_back('{"rst_irq", 32'h0});
    ticks(2);
    bus_read(0, PIO_DATA, got);
    e = exp_q.pop_front(); total++;
    if (got !== e.val) begin bad++; $display("[TB] FAIL %s got=%h exp=%h", e.name, got, e.val); end
    bus_read(0, PIO_EDGECAP, got);
    e = exp_q.pop_front(); total++;
    if (got !== e.val) begin bad++; $display("[TB] FAIL %s got=%h exp=%h", e.name, got, e.val); end
    got = {31'b0, irq_r};
    e = exp_q.pop_front(); total++;
    if (got !== e.val) begin bad++; $display("[TB] FAIL %s got=%h exp=%h", e.name, got, e.val); end

    reset_n = 1'b1;
    exp_q.push_back('{"data_after_1clk", 32'h0});
    exp_q.push_back('{"data_after_2clk", 32'hA5});
    exp_q.push_back('{"edgecap_after_2clk", 32'h0});
    exp_q.push_back('{"edgecap_after_3clk", 32'hA5});
    exp_q.push_back('{"irq_mask0", 32'h0});
    exp_q.push_back('{"read_no_cs", 32'h0});
    ticks(1);
    bus_read(0, PIO_DATA, got);
    e = exp_q.pop_front(); total++;
    if (got !== e.val) begin bad++; $display("[TB] FAIL %s got=%h exp=%h", e.name, got, e.val); end
    ticks(1);
    bus_read(0, PIO_DATA, got);
    e = exp_q.pop_front(); total++;
    if (got !== e.val) begin bad++; $display("[TB] FAIL %s got=%h exp=%h", e.name, got, e.val); end
    bus_read(0, PIO_EDGECAP, got);
    e = exp_q.pop_front(); total++;
    if (got !== e.val) begin bad++; $display("[TB] FAIL %s got=%h exp=%h", e.name, got, e.val); end
    ticks(1);
    bus_read(0, PIO_EDGECAP, got);
    e = exp_q.pop_front(); total++;
    if (got !== e.val) begin bad++; $display("[TB] FAIL %s got=%h exp=%h", e.name, got, e.val); end
    got = {31'b0, irq_r};
    e = exp_q.pop_front(); total++;
    if (got !== e.val) begin bad++; $display("[TB] FAIL %s got=%h exp=%h", e.name, got, e.val); end
    chipselect = 1'b0; address = PIO_DATA; #1;
    got = rd_r;
    e = exp_q.pop_front(); total++;
    if (got !== e.val) begin bad++; $display("[TB] FAIL %s got=%h exp=%h", e.name, got, e.val); end
  endtask

  task automatic test_irq_mask;
    in_r = 8'hA4;
    ticks(4);
    bus_write(PIO_EDGECAP, 32'hFF);
    bus_write(PIO_IRQMASK, 32'h01);
    exp_q.push_back('{"mask_readback", 32'h01});
    bus_read(0, PIO_IRQMASK, got);
    e = exp_q.pop_front(); total++;
    if (got !== e.val) begin bad++; $display("[TB] FAIL %s got=%h exp=%h", e.name, got, e.val); end

    in_r = 8'hA5;
    exp_q.push_back('{"bit0_edgecap_2clk", 32'h00});
    exp_q.push_back('{"bit0_edgecap_3clk", 32'h01});
    exp_q.push_back('{"bit0_irq_3clk", 32'h0});
    exp_q.push_back('{"bit0_irq_4clk", 32'h1});
    ticks(2);
    bus_read(0, PIO_EDGECAP, got);
    e = exp_q.pop_front(); total++;
    if (got !== e.val) begin bad++; $display("[TB] FAIL %s got=%h exp=%h", e.name, got, e.val); end
    ticks(1);
    bus_read(0, PIO_EDGECAP, got);
    e = exp_q.pop_front(); total++;
    if (got !== e.val) begin bad++; $display("[TB] FAIL %s got=%h exp=%h", e.name, got, e.val); end
    got = {31'b0, irq_r};
    e = exp_q.pop_front(); total++;
    if (got !== e.val) begin bad++; $display("[TB] FAIL %s got=%h exp=%h", e.name, got, e.val); end
    ticks(1);
    got = {31'b0, irq_r};
    e = exp_q.pop_front(); total++;
    if (got !== e.val) begin bad++; $display("[TB] FAIL %s got=%h exp=%h", e.name, got, e.val); end

    exp_q.push_back('{"clear_edgecap", 32'h00});
    exp_q.push_back('{"clear_irq_same_clk", 32'h1});
    exp_q.push_back('{"clear_irq_next_clk", 32'h0});
    bus_write(PIO_EDGECAP, 32'h01);
    bus_read(0, PIO_EDGECAP, got);
    e = exp_q.pop_front(); total++;
    if (got !== e.val) begin bad++; $display("[TB] FAIL %s got=%h exp=%h", e.name, got, e.val); end
    got = {31'b0, irq_r};
    e = exp_q.pop_front(); total++;
    if (got !== e.val) begin bad++; $display("[TB] FAIL %s got=%h exp=%h", e.name, got, e.val); end
    ticks(1);
    got = {31'b0, irq_r};
    e = exp_q.pop_front(); total++;
    if (got !== e.val) begin bad++; $display("[TB] FAIL %s got=%h exp=%h", e.name, got, e.val); end
  endtask

  task automatic test_set_wins;
    in_r = 8'hA4; ticks(3);
    in_r = 8'hA5; ticks(4);
    exp_q.push_back('{"pre_irq", 32'h1});
    got = {31'b0, irq_r};
    e = exp_q.pop_front(); total++;
    if (got !== e.val) begin bad++; $display("[TB] FAIL %s got=%h exp=%h", e.name, got, e.val); end

    in_r = 8'hA4; ticks(3);
    in_r = 8'hA5; ticks(2);
    exp_q.push_back('{"setwin_edgecap", 32'h01});
    exp_q.push_back('{"setwin_irq", 32'h1});
    exp_q.push_back('{"setwin_irq_next", 32'h1});
    exp_q.push_back('{"setwin_cleanup_irq", 32'h0});
    bus_write(PIO_EDGECAP, 32'h01);
    bus_read(0, PIO_EDGECAP, got);
    e = exp_q.pop_front(); total++;
    if (got !== e.val) begin bad++; $display("[TB] FAIL %s got=%h exp=%h", e.name, got, e.val); end
    got = {31'b0, irq_r};
    e = exp_q.pop_front(); total++;
    if (got !== e.val) begin bad++; $display("[TB] FAIL %s got=%h exp=%h", e.name, got, e.val); end
    ticks(1);
    got = {31'b0, irq_r};
    e = exp_q.pop_front(); total++;
    if (got !== e.val) begin bad++; $display("[TB] FAIL %s got=%h exp=%h", e.name, got, e.val); end
    bus_write(PIO_EDGECAP, 32'hFF);
    ticks(1);
    got = {31'b0, irq_r};
    e = exp_q.pop_front(); total++;
    if (got !== e.val) begin bad++; $display("[TB] FAIL %s got=%h exp=%h", e.name, got, e.val); end
  endtask

  task automatic test_falling;
    in_f = 8'hFF; ticks(4);
    bus_write(PIO_EDGECAP, 32'hFF);
    in_f = 8'h0F;
    exp_q.push_back('{"fall_data_2clk", 32'h0F});
    exp_q.push_back('{"fall_edgecap_2clk", 32'h00});
    exp_q.push_back('{"fall_edgecap_3clk", 32'hF0});
    exp_q.push_back('{"fall_irq_masked", 32'h0});
    ticks(2);
    bus_read(1, PIO_DATA, got);
    e = exp_q.pop_front(); total++;
    if (got !== e.val) begin bad++; $display("[TB] FAIL %s got=%h exp=%h", e.name, got, e.val); end
    bus_read(1, PIO_EDGECAP, got);
    e = exp_q.pop_front(); total++;
    if (got !== e.val) begin bad++; $display("[TB] FAIL %s got=%h exp=%h", e.name, got, e.val); end
    ticks(1);
    bus_read(1, PIO_EDGECAP, got);
    e = exp_q.pop_front(); total++;
    if (got !== e.val) begin bad++; $display("[TB] FAIL %s got=%h exp=%h", e.name, got, e.val); end
    ticks(1);
    got = {31'b0, irq_f};
    e = exp_q.pop_front(); total++;
    if (got !== e.val) begin bad++; $display("[TB] FAIL %s got=%h exp=%h", e.name, got, e.val); end
  endtask

  task automatic test_any;
    in_a = 8'h08;
    exp_q.push_back('{"any_rise_edgecap", 32'h08});
    exp_q.push_back('{"any_after_clear", 32'h00});
    ticks(3);
    bus_read(2, PIO_EDGECAP, got);
    e = exp_q.pop_front(); total++;
    if (got !== e.val) begin bad++; $display("[TB] FAIL %s got=%h exp=%h", e.name, got, e.val); end
    bus_write(PIO_EDGECAP, 32'h08);
    bus_read(2, PIO_EDGECAP, got);
    e = exp_q.pop_front(); total++;
    if (got !== e.val) begin bad++; $display("[TB] FAIL %s got=%h exp=%h", e.name, got, e.val); end

    in_a = 8'h00;
    exp_q.push_back('{"any_fall_edgecap_2clk", 32'h00});
    exp_q.push_back('{"any_fall_edgecap_3clk", 32'h08});
    ticks(2);
    bus_read(2, PIO_EDGECAP, got);
    e = exp_q.pop_front(); total++;
    if (got !== e.val) begin bad++; $display("[TB] FAIL %s got=%h exp=%h", e.name, got, e.val); end
    ticks(1);
    bus_read(2, PIO_EDGECAP, got);
    e = exp_q.pop_front(); total++;
    if (got !== e.val) begin bad++; $display("[TB] FAIL %s got=%h exp=%h", e.name, got, e.val); end
  endtask

  task automatic test_upper_ignored;
    in_r = 8'h00; ticks(3);
    bus_write(PIO_EDGECAP, 32'hFF);
    in_r = 8'h3C; ticks(3);
    exp_q.push_back('{"cap_3c", 32'h3C});
    exp_q.push_back('{"upper_clear_ignored", 32'h3C});
    exp_q.push_back('{"reserved_reads_0", 32'h0});
    exp_q.push_back('{"data_write_ignored", 32'h3C});
    exp_q.push_back('{"mask_upper_ignored", 32'h00});
    exp_q.push_back('{"mask_trunc", 32'h3C});
    exp_q.push_back('{"mask_irq_same_clk", 32'h0});
    exp_q.push_back('{"mask_irq_next_clk", 32'h1});
    bus_read(0, PIO_EDGECAP, got);
    e = exp_q.pop_front(); total++;
    if (got !== e.val) begin bad++; $display("[TB] FAIL %s got=%h exp=%h", e.name, got, e.val); end
    bus_write(PIO_EDGECAP, 32'hFFFF_FF00);
    bus_read(0, PIO_EDGECAP, got);
    e = exp_q.pop_front(); total++;
    if (got !== e.val) begin bad++; $display("[TB] FAIL %s got=%h exp=%h", e.name, got, e.val); end
    bus_write(PIO_RESERVED, 32'hFFFF_FFFF);
    bus_write(PIO_DATA, 32'hFFFF_FFFF);
    bus_read(0, PIO_RESERVED, got);
    e = exp_q.pop_front(); total++;
    if (got !== e.val) begin bad++; $display("[TB] FAIL %s got=%h exp=%h", e.name, got, e.val); end
    bus_read(0, PIO_DATA, got);
    e = exp_q.pop_front(); total++;
    if (got !== e.val) begin bad++; $display("[TB] FAIL %s got=%h exp=%h", e.name, got, e.val); end
    bus_write(PIO_IRQMASK, 32'hFFFF_FF00);
    bus_read(0, PIO_IRQMASK, got);
    e = exp_q.pop_front(); total++;
    if (got !== e.val) begin bad++; $display("[TB] FAIL %s got=%h exp=%h", e.name, got, e.val); end
    bus_write(PIO_IRQMASK, 32'hABCD_EF3C);
    bus_read(0, PIO_IRQMASK, got);
    e = exp_q.pop_front(); total++;
    if (got !== e.val) begin bad++; $display("[TB] FAIL %s got=%h exp=%h", e.name, got, e.val); end
    got = {31'b0, irq_r};
    e = exp_q.pop_front(); total++;
    if (got !== e.val) begin bad++; $display("[TB] FAIL %s got=%h exp=%h", e.name, got, e.val); end
    ticks(1);
    got = {31'b0, irq_r};
    e = exp_q.pop_front(); total++;
    if (got !== e.val) begin bad++; $display("[TB] FAIL %s got=%h exp=%h", e.name, got, e.val); end
  endtask

  task automatic test_reset_mid;
    in_r = 8'hFF; ticks(3);
    bus_write(PIO_IRQMASK, 32'hFF);
    ticks(1);
    exp_q.push_back('{"mid_pre_edgecap", 32'hFF});
    exp_q.push_back('{"mid_pre_irq", 32'h1});
    exp_q.push_back('{"mid_rst_irq", 32'h0});
    exp_q.push_back('{"mid_rst_edgecap", 32'h0});
    exp_q.push_back('{"mid_rst_mask", 32'h0});
    exp_q.push_back('{"mid_rst_data", 32'h0});
    bus_read(0, PIO_EDGECAP, got);
    e = exp_q.pop_front(); total++;
    if (got !== e.val) begin bad++; $display("[TB] FAIL %s got=%h exp=%h", e.name, got, e.val); end
    got = {31'b0, irq_r};
    e = exp_q.pop_front(); total++;
    if (got !== e.val) begin bad++; $display("[TB] FAIL %s got=%h exp=%h", e.name, got, e.val); end

    @(negedge clk);
    reset_n = 1'b0;
    #1;
    got = {31'b0, irq_r};
    e = exp_q.pop_front(); total++;
    if (got !== e.val) begin bad++; $display("[TB] FAIL %s got=%h exp=%h", e.name, got, e.val); end
    bus_read(0, PIO_EDGECAP, got);
    e = exp_q.pop_front(); total++;
    if (got !== e.val) begin bad++; $display("[TB] FAIL %s got=%h exp=%h", e.name, got, e.val); end
    bus_read(0, PIO_IRQMASK, got);
    e = exp_q.pop_front(); total++;
    if (got !== e.val) begin bad++; $display("[TB] FAIL %s got=%h exp=%h", e.name, got, e.val); end
    bus_read(0, PIO_DATA, got);
    e = exp_q.pop_front(); total++;
    if (got !== e.val) begin bad++; $display("[TB] FAIL %s got=%h exp=%h", e.name, got, e.val); end

    @(negedge clk);
    reset_n = 1'b1;
    exp_q.push_back('{"post_rst_recapture", 32'hFF});
    exp_q.push_back('{"post_rst_irq_masked", 32'h0});
    ticks(3);
    bus_read(0, PIO_EDGECAP, got);
    e = exp_q.pop_front(); total++;
    if (got !== e.val) begin bad++; $display("[TB] FAIL %s got=%h exp=%h", e.name, got, e.val); end
    ticks(2);
    got = {31'b0, irq_r};
    e = exp_q.pop_front(); total++;
    if (got !== e.val) begin bad++; $display("[TB] FAIL %s got=%h exp=%h", e.name, got, e.val); end
  endtask

  // Guard against a stalled run
  initial begin
    #100000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Test sequence
  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_irq_mask();
    test_set_wins();
    test_falling();
    test_any();
    test_upper_ignored();
    test_reset_mid();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
